// File: rtl/bit_assembler.sv
// Collects single bits into an nrOfOutputBits word at position sel and tracks written positions.
// Latency: dataValid rises the cycle after the completing or flushing transfer.
// Backpressure: while a word is held, a bit is accepted only in the cycle dataReady takes the word.
module bit_assembler #(
   parameter int nrOfOutputBits = 8,
   parameter int nrOfselBits    = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      bitIn,
   input  logic [nrOfselBits-1:0]    sel,
   input  logic                      bitValid,
   output logic                      bitReady,
   input  logic                      flush,
   output logic [nrOfOutputBits-1:0] dataOut,
   output logic                      dataValid,
   input  logic                      dataReady,
   output logic [nrOfOutputBits-1:0] writtenMask,
   output logic                      selError
);

   typedef enum logic {COLLECT, HOLD} stateType;

   // One extra bit so the limit fits even when 2^nrOfselBits == nrOfOutputBits.
   localparam logic [nrOfselBits:0]    selLimit = (nrOfselBits+1)'(nrOfOutputBits);
   localparam logic [nrOfOutputBits-1:0] allOnes = '1;

   stateType                  state;
   stateType                  nextState;
   logic [nrOfOutputBits-1:0] word;
   logic [nrOfOutputBits-1:0] nextWord;
   logic [nrOfOutputBits-1:0] nextMask;
   logic [nrOfOutputBits-1:0] baseWord;
   logic [nrOfOutputBits-1:0] baseMask;
   logic [nrOfOutputBits-1:0] selOneHot;
   logic                      inRange;
   logic                      transfer;
   logic                      takeWord;
   logic                      loadOut;

   assign dataValid = (state == HOLD);
   assign bitReady  = (state == COLLECT) | dataReady;
   assign transfer  = bitValid & bitReady;
   assign takeWord  = (state == HOLD) & dataReady;
   assign inRange   = ({1'b0, sel} < selLimit);
   assign selOneHot = {{(nrOfOutputBits-1){1'b0}}, 1'b1} << sel;

   // Taking the held word starts a fresh one, so a same-cycle bit lands in an empty word.
   assign baseWord  = takeWord ? '0 : word;
   assign baseMask  = takeWord ? '0 : writtenMask;

   always_comb begin
      nextWord  = baseWord;
      nextMask  = baseMask;
      nextState = state;
      loadOut   = 1'b0;
      if (transfer && inRange) begin
         nextMask = baseMask | selOneHot;
         nextWord = bitIn ? (baseWord | selOneHot) : (baseWord & ~selOneHot);
      end
      case (state)
         COLLECT: begin
            if ((nextMask == allOnes) || (flush && (nextMask != '0))) begin
               nextState = HOLD;
               loadOut   = 1'b1;
            end
         end
         HOLD: begin
            if (dataReady) nextState = COLLECT;
         end
         default: nextState = COLLECT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= COLLECT;
         word        <= '0;
         writtenMask <= '0;
         dataOut     <= '0;
         selError    <= 1'b0;
      end else begin
         state       <= nextState;
         word        <= nextWord;
         writtenMask <= nextMask;
         selError    <= transfer & ~inRange;
         if (loadOut) dataOut <= nextWord;
      end
   end

endmodule

// File: tb/tb_bit_assembler.sv
// Bench for bit_assembler: an 8-bit instance driven through a word scoreboard, and a 6-bit instance
// for out-of-range sel handling.
module tb_bit_assembler;

   logic       clock = 1'b0;
   logic       reset;
   logic       bitIn, bitValid, flush, dataReady;
   logic [2:0] sel;
   logic       bitReady, dataValid, selError;
   logic [7:0] dataOut, writtenMask;

   logic       bBitIn, bBitValid, bFlush, bDataReady;
   logic [2:0] bSel;
   logic       bBitReady, bDataValid, bSelError;
   logic [5:0] bDataOut, bWrittenMask;

   int         nChecks = 0;
   int         nPass   = 0;
   logic [7:0] expQ[$];
   logic [7:0] modelWord, modelMask;

   bit_assembler #(.nrOfOutputBits(8), .nrOfselBits(3)) dut (
      .clock(clock), .reset(reset), .bitIn(bitIn), .sel(sel), .bitValid(bitValid),
      .bitReady(bitReady), .flush(flush), .dataOut(dataOut), .dataValid(dataValid),
      .dataReady(dataReady), .writtenMask(writtenMask), .selError(selError)
   );

   bit_assembler #(.nrOfOutputBits(6), .nrOfselBits(3)) dutB (
      .clock(clock), .reset(reset), .bitIn(bBitIn), .sel(bSel), .bitValid(bBitValid),
      .bitReady(bBitReady), .flush(bFlush), .dataOut(bDataOut), .dataValid(bDataValid),
      .dataReady(bDataReady), .writtenMask(bWrittenMask), .selError(bSelError)
   );

   always #5 clock = ~clock;

   // Advances one cycle; at the falling edge, a word about to be accepted is checked against the scoreboard.
   task automatic tick();
      logic [7:0] expWord;
      @(negedge clock);
      if (reset === 1'b1 && dataValid === 1'b1 && dataReady === 1'b1) begin
         nChecks++;
         if (expQ.size() == 0) begin
            $display("FAIL sb_unexpected: got word %h, none expected", dataOut);
         end else begin
            expWord = expQ.pop_front();
            if (dataOut !== expWord) $display("FAIL sb_word: got %h want %h", dataOut, expWord);
            else nPass++;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic putBit(input logic [2:0] s, input logic b);
      sel = s; bitIn = b; bitValid = 1'b1;
      tick();
      bitValid = 1'b0;
      modelWord[s] = b;
      modelMask[s] = 1'b1;
      if (modelMask == 8'hFF) begin
         expQ.push_back(modelWord);
         modelWord = '0; modelMask = '0;
      end
   endtask

   task automatic doFlush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (modelMask != '0) expQ.push_back(modelWord);
      modelWord = '0; modelMask = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(); tick();
      nChecks++; if (dataValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dataValid); else nPass++;
      nChecks++; if (writtenMask !== 8'h00) $display("FAIL rst_mask: got %h want 00", writtenMask); else nPass++;
      nChecks++; if (dataOut !== 8'h00) $display("FAIL rst_data: got %h want 00", dataOut); else nPass++;
      nChecks++; if (selError !== 1'b0) $display("FAIL rst_selerr: got %b want 0", selError); else nPass++;
      reset = 1'b1;
      nChecks++; if (bitReady !== 1'b1) $display("FAIL rst_ready: got %b want 1", bitReady); else nPass++;
   endtask

   task automatic test_sequential();
      logic [7:0] pat;
      pat = 8'b0100_1101;
      dataReady = 1'b1;
      for (int i = 0; i < 8; i++) putBit(3'(i), pat[i]);
      nChecks++; if (dataValid !== 1'b1) $display("FAIL seq_valid: got %b want 1", dataValid); else nPass++;
      nChecks++; if (dataOut !== 8'h4D) $display("FAIL seq_data: got %h want 4d", dataOut); else nPass++;
      tick();
      nChecks++; if (dataValid !== 1'b0) $display("FAIL seq_taken: got %b want 0", dataValid); else nPass++;
      nChecks++; if (writtenMask !== 8'h00) $display("FAIL seq_mask: got %h want 00", writtenMask); else nPass++;
      dataReady = 1'b0;
   endtask

   task automatic test_hold_backpressure();
      for (int i = 7; i >= 0; i--) putBit(3'(i), 1'b1);
      sel = 3'd0; bitIn = 1'b0; bitValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         nChecks++; if (dataValid !== 1'b1) $display("FAIL hold_valid: got %b want 1", dataValid); else nPass++;
         nChecks++; if (dataOut !== 8'hFF) $display("FAIL hold_data: got %h want ff", dataOut); else nPass++;
         nChecks++; if (bitReady !== 1'b0) $display("FAIL hold_ready: got %b want 0", bitReady); else nPass++;
         tick();
      end
      bitValid = 1'b0;
      dataReady = 1'b1;
      tick();
      dataReady = 1'b0;
      nChecks++; if (writtenMask !== 8'h00) $display("FAIL hold_mask_after: got %h want 00", writtenMask); else nPass++;
   endtask

   task automatic test_flush();
      putBit(3'd2, 1'b1);
      putBit(3'd5, 1'b1);
      doFlush();
      nChecks++; if (dataValid !== 1'b1) $display("FAIL flush_valid: got %b want 1", dataValid); else nPass++;
      nChecks++; if (dataOut !== 8'h24) $display("FAIL flush_data: got %h want 24", dataOut); else nPass++;
      dataReady = 1'b1;
      tick();
      dataReady = 1'b0;
      flush = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         nChecks++; if (dataValid !== 1'b0) $display("FAIL flush_empty: got %b want 0", dataValid); else nPass++;
      end
      flush = 1'b0;
   endtask

   task automatic test_rewrite();
      putBit(3'd3, 1'b1);
      nChecks++; if (writtenMask !== 8'h08) $display("FAIL rew_mask1: got %h want 08", writtenMask); else nPass++;
      putBit(3'd3, 1'b0);
      nChecks++; if (writtenMask !== 8'h08) $display("FAIL rew_mask2: got %h want 08", writtenMask); else nPass++;
      doFlush();
      nChecks++; if (dataValid !== 1'b1) $display("FAIL rew_valid: got %b want 1", dataValid); else nPass++;
      nChecks++; if (dataOut !== 8'h00) $display("FAIL rew_data: got %h want 00", dataOut); else nPass++;
      dataReady = 1'b1;
      tick();
      dataReady = 1'b0;
   endtask

   task automatic test_sel_error();
      bSel = 3'd1; bBitIn = 1'b1; bBitValid = 1'b1;
      tick();
      bBitValid = 1'b0;
      nChecks++; if (bWrittenMask !== 6'h02) $display("FAIL selerr_pre_mask: got %h want 02", bWrittenMask); else nPass++;
      bSel = 3'd7; bBitValid = 1'b1;
      nChecks++; if (bBitReady !== 1'b1) $display("FAIL selerr_ready: got %b want 1", bBitReady); else nPass++;
      tick();
      bBitValid = 1'b0;
      nChecks++; if (bSelError !== 1'b1) $display("FAIL selerr_pulse: got %b want 1", bSelError); else nPass++;
      nChecks++; if (bWrittenMask !== 6'h02) $display("FAIL selerr_mask: got %h want 02", bWrittenMask); else nPass++;
      nChecks++; if (bDataValid !== 1'b0) $display("FAIL selerr_noword: got %b want 0", bDataValid); else nPass++;
      tick();
      nChecks++; if (bSelError !== 1'b0) $display("FAIL selerr_once: got %b want 0", bSelError); else nPass++;
      for (int i = 0; i < 6; i++) begin
         if (i != 1) begin
            bSel = 3'(i); bBitIn = 1'b1; bBitValid = 1'b1;
            tick();
            bBitValid = 1'b0;
         end
      end
      nChecks++; if (bDataValid !== 1'b1) $display("FAIL b_full_valid: got %b want 1", bDataValid); else nPass++;
      nChecks++; if (bDataOut !== 6'h3F) $display("FAIL b_full_data: got %h want 3f", bDataOut); else nPass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) putBit(3'(i), pat[i]);
      nChecks++; if (dataValid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", dataValid); else nPass++;
      dataReady = 1'b1; sel = 3'd1; bitIn = 1'b1; bitValid = 1'b1;
      #1;
      nChecks++; if (bitReady !== 1'b1) $display("FAIL b2b_ready: got %b want 1", bitReady); else nPass++;
      tick();
      bitValid = 1'b0;
      modelWord = 8'h02; modelMask = 8'h02;
      nChecks++; if (dataValid !== 1'b0) $display("FAIL b2b_taken: got %b want 0", dataValid); else nPass++;
      nChecks++; if (writtenMask !== 8'h02) $display("FAIL b2b_mask: got %h want 02", writtenMask); else nPass++;
      for (int i = 0; i < 8; i++) if (i != 1) putBit(3'(i), 1'b0);
      nChecks++; if (dataValid !== 1'b1) $display("FAIL b2b_valid2: got %b want 1", dataValid); else nPass++;
      nChecks++; if (dataOut !== 8'h02) $display("FAIL b2b_data2: got %h want 02", dataOut); else nPass++;
      tick();
      dataReady = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) putBit(3'(i), 1'b1);
      nChecks++; if (writtenMask !== 8'h0F) $display("FAIL rmid_mask: got %h want 0f", writtenMask); else nPass++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      modelWord = '0; modelMask = '0;
      nChecks++; if (dataValid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", dataValid); else nPass++;
      nChecks++; if (writtenMask !== 8'h00) $display("FAIL rmid_mask0: got %h want 00", writtenMask); else nPass++;
      nChecks++; if (dataOut !== 8'h00) $display("FAIL rmid_data: got %h want 00", dataOut); else nPass++;
      for (int i = 0; i < 8; i++) putBit(3'(i), 1'b1);
      nChecks++; if (dataValid !== 1'b1) $display("FAIL rhold_pre: got %b want 1", dataValid); else nPass++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      expQ.delete();
      nChecks++; if (dataValid !== 1'b0) $display("FAIL rhold_valid: got %b want 0", dataValid); else nPass++;
      nChecks++; if (writtenMask !== 8'h00) $display("FAIL rhold_mask: got %h want 00", writtenMask); else nPass++;
      nChecks++; if (dataOut !== 8'h00) $display("FAIL rhold_data: got %h want 00", dataOut); else nPass++;
   endtask

   initial begin
      reset = 1'b0; bitIn = 1'b0; bitValid = 1'b0; flush = 1'b0; dataReady = 1'b0; sel = '0;
      bBitIn = 1'b0; bBitValid = 1'b0; bFlush = 1'b0; bDataReady = 1'b0; bSel = '0;
      modelWord = '0; modelMask = '0;
      test_reset();
      test_sequential();
      test_hold_backpressure();
      test_flush();
      test_rewrite();
      test_sel_error();
      test_back_to_back();
      test_reset_mid();
      nChecks++;
      if (expQ.size() != 0) $display("FAIL sb_leftover: got %0d pending words want 0", expQ.size());
      else nPass++;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

endmodule
